// File: rtl/dm_pkg.sv
// dm_pkg: shared size encodings and controller states for the byte-enabled data memory
package dm_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: load lane extraction with sign/zero extension, store byte enables and lane-shifted write data
// lane: byte offset in word (already aligned), size: clamped access size, load_signed: extend mode,
// word: addressed memory word, wdata: right-aligned store data,
// load_data: extended load result, store_data: wdata shifted to lane, be: per-byte write enables
module dm_lane_align
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int LW = NB > 1 ? $clog2(NB) : 1
) (
  input  logic [LW-1:0]         lane,
  input  logic [1:0]            size,
  input  logic                  load_signed,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [NB-1:0]         be
);
  int nb;
  logic [DATA_WIDTH-1:0] sh;
  logic msb;
  always_comb begin
    nb = size == SIZE_BYTE ? 1 : size == SIZE_HALF ? 2 : size == SIZE_WORD ? 4 : size == SIZE_DWORD ? 8 : 1;
    sh = word >> {lane, 3'b000};
    msb = load_signed & sh[8*nb-1];
    load_data = '0;
    be = '0;
    for (int i = 0; i < NB; i++) begin
      load_data[8*i+:8] = i < nb ? sh[8*i+:8] : {8{msb}};
      be[i] = i >= int'(lane) && i < int'(lane) + nb;
    end
    store_data = wdata << {lane, 3'b000};
  end
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressable data memory with sized loads/stores and sequential clear after reset
// clk, reset (sync, active-high): clock and reset; addr: byte address; wdata: right-aligned store data;
// rd_en/wr_en: load/store request; size: 2^size bytes; load_signed: sign- vs zero-extend;
// rdata: extended load result; busy: clear in progress; misalign: illegal access flag.
// Optional macro DM_ALIGN_CHECK_EN: flag and suppress misaligned or oversized accesses instead of
// aligning them down / clamping them to a full word.
module data_memory_be
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [1:0]            size,
  input  logic                  load_signed,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  misalign
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int LW = LB > 0 ? LB : 1;
  localparam int IW = $clog2(WORDS);
  localparam logic [1:0] FULL = 2'(LB > 3 ? 3 : LB);
  state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, widx;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [LW-1:0] lane, lane_al;
  logic [1:0] eff;
  logic ok, we, re;
  logic [DATA_WIDTH-1:0] ld, wsd;
  logic [NB-1:0] be;
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_WIDTH-1:IW+LB];
  assign widx = addr[IW+LB-1:LB];
  assign lane = addr[LW-1:0];
  assign ok = int'(32'd1 << size) <= NB;
  assign eff = ok ? size : FULL;
  // Without the alignment check, low lane bits below the access size are dropped (align down).
  assign lane_al = lane & ~LW'((32'd1 << eff) - 32'd1);
  assign busy = state == CLEAR;
`ifdef DM_ALIGN_CHECK_EN
  assign misalign = (rd_en | wr_en) & ~busy & (~ok | ((lane & LW'((32'd1 << size) - 32'd1)) != '0));
`else
  assign misalign = 1'b0;
`endif
  assign we = wr_en & ~busy & ~misalign;
  assign re = rd_en & ~busy & ~misalign;
  assign rdata = re ? ld : '0;
  dm_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .lane(lane_al),
    .size(eff),
    .load_signed(load_signed),
    .word(mem[widx]),
    .wdata(wdata),
    .load_data(ld),
    .store_data(wsd),
    .be(be)
  );
  always_comb begin
    state_nxt = state == CLEAR && idx == IW'(WORDS - 1) ? IDLE : state;
    idx_nxt = state == CLEAR ? idx + IW'(1) : idx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) mem[idx] <= '0;
    else if (we)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[widx][8*i+:8] <= wsd[8*i+:8];
  end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: directed table-driven checks of loads, stores, clear sequencing and corner cases
module tb_data_memory_be;
  logic clk = 1'b0;
  logic reset, rd_en, wr_en, load_signed, busy, misalign;
  logic [31:0] addr, wdata, rdata;
  logic [1:0] size;
  int n_chk = 0;
  int n_fail = 0;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct packed {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0] s;
    logic sg;
    logic [31:0] exp;
    logic mis;
  } vec_t;
  vec_t v [18];
  always #5 clk = ~clk;
  data_memory_be #(.DATA_WIDTH(32), .WORDS(16), .ADDR_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .size(size),
    .load_signed(load_signed),
    .rdata(rdata),
    .busy(busy),
    .misalign(misalign)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic sg);
    rd_en = r;
    wr_en = w;
    addr = a;
    wdata = d;
    size = s;
    load_signed = sg;
  endtask
  task automatic wait_clear(input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, 16);
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b1, 32'h8,  32'h8899AABB, 2'd2, 1'b0, 32'h0, 1'b0};
    v[1]  = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd0, 1'b1, 32'hFFFFFFBB, 1'b0};
    v[2]  = '{1'b1, 1'b0, 32'hB,  32'h0, 2'd0, 1'b0, 32'h00000088, 1'b0};
    v[3]  = '{1'b1, 1'b0, 32'hA,  32'h0, 2'd1, 1'b1, 32'hFFFF8899, 1'b0};
    v[4]  = '{1'b1, 1'b0, 32'hA,  32'h0, 2'd1, 1'b0, 32'h00008899, 1'b0};
    v[5]  = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd2, 1'b0, 32'h8899AABB, 1'b0};
    v[6]  = '{1'b0, 1'b1, 32'h9,  32'hFFFFFF5A, 2'd0, 1'b0, 32'h0, 1'b0};
    v[7]  = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd2, 1'b0, 32'h88995ABB, 1'b0};
    v[8]  = '{1'b0, 1'b1, 32'hA,  32'hABCD1234, 2'd1, 1'b0, 32'h0, 1'b0};
    v[9]  = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd2, 1'b0, 32'h12345ABB, 1'b0};
    v[10] = '{1'b1, 1'b0, 32'h9,  32'h0, 2'd0, 1'b1, 32'h0000005A, 1'b0};
    v[11] = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd1, 1'b1, 32'h00005ABB, 1'b0};
    v[12] = '{1'b1, 1'b0, 32'h48, 32'h0, 2'd2, 1'b0, 32'h12345ABB, 1'b0};
    v[13] = '{1'b0, 1'b0, 32'h8,  32'h0, 2'd2, 1'b0, 32'h0, 1'b0};
    v[14] = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd3, 1'b0, CHK ? 32'h0 : 32'h12345ABB, CHK};
    v[15] = '{1'b1, 1'b0, 32'h9,  32'h0, 2'd1, 1'b1, CHK ? 32'h0 : 32'h00005ABB, CHK};
    v[16] = '{1'b1, 1'b0, 32'hB,  32'h0, 2'd0, 1'b1, 32'h00000012, 1'b0};
    v[17] = '{1'b1, 1'b0, 32'h8,  32'h0, 2'd1, 1'b0, 32'h00005ABB, 1'b0};
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_misalign", misalign, 0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 2'd2, 1'b0);
    wait_clear("clear_len");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'(4 * i), 32'h0, 2'd2, 1'b0);
      #1 chk($sformatf("cleared_w%0d", i), rdata, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 18; i++) begin
      drive(v[i].rd, v[i].wr, v[i].a, v[i].d, v[i].s, v[i].sg);
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, v[i].exp);
      chk($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, v[i].mis});
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 2'd2, 1'b0);
    #1 chk("rw_same_old", rdata, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    #1 chk("rw_same_new", rdata, 32'hCAFEF00D);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h6, 32'h11223344, 2'd2, 1'b0);
    #1 chk("sw6_misalign", {31'b0, misalign}, {31'b0, CHK});
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0);
    #1 chk("sw6_word4", rdata, CHK ? 32'h0 : 32'h11223344);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midclear_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_clear("reclear_len");
    drive(1'b1, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0);
    #1 chk("reclear_w2", rdata, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    #1 chk("reclear_w4", rdata, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised, byte-addressable data memory for the CPU datapath, successor to the word-only data memory. Supports byte/half/word (and wider, by parameter) loads with zero/sign extension and byte-lane stores. Clears its array sequentially after reset, one word per cycle, and exposes a busy flag. Sits behind the ALU address output in the MEM stage, replacing the word-only memory.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8, power-of-two byte count.
- WORDS, 1024: number of words; power of two.
- ADDR_WIDTH, 32: width of the byte address input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data, right-aligned (low bytes used).
- rd_en  in  1  load request.
- wr_en  in  1  store request.
- size  in  2  access size = 2^size bytes (0 byte, 1 half, 2 word, 3 dword).
- load_signed  in  1  1: sign-extend loaded value; 0: zero-extend.
- rdata  out  DATA_WIDTH  load result, right-aligned and extended.
- busy  out  1  array clear in progress; accesses ignored.
- misalign  out  1  current access illegal (only with DM_ALIGN_CHECK_EN).

## Operation
- LB = log2(DATA_WIDTH/8). Word index = addr[log2(WORDS)+LB-1:LB]; lane = addr[LB-1:0]. Upper address bits ignored: addresses wrap modulo WORDS*DATA_WIDTH/8.
- FSM states: IDLE, CLEAR. reset=1 at a clk edge: state <= CLEAR, clear index <= 0. In CLEAR: mem[index] <= 0 each cycle, index increments. index == WORDS-1 cleared -> IDLE.
- reset held high: stays in CLEAR with index pinned at 0. reset reasserted mid-clear restarts from index 0.
- busy = (state == CLEAR). While busy: stores dropped, rdata = 0, misalign = 0.
- Load (IDLE, rd_en=1): bytes [lane, lane+2^size) of mem[index] placed in rdata low bytes, upper bits filled with the MSB of the loaded field if load_signed, else 0. size with 2^size > DATA_WIDTH/8 is illegal.
- rd_en=0: rdata = 0 (never X).
- Store (IDLE, wr_en=1): at posedge, the low 2^size bytes of wdata are written to lanes [lane, lane+2^size) of mem[index]. Other lanes unchanged.
- Illegal size, without check: clamped to full word.
- Simultaneous rd_en and wr_en, same word: rdata shows pre-write contents; the new value is visible from the next cycle.

## Timing
- Reads combinational: rdata valid in the same cycle as addr/size/load_signed/rd_en, no clock latency.
- Writes take effect at the posedge where wr_en=1 and state IDLE.
- After reset deasserts, busy stays high for exactly WORDS cycles. busy is 0 in the first cycle after the clear of word WORDS-1.
- Reset values: busy=1 (state CLEAR), rdata=0, misalign=0.

## Configuration
- DM_ALIGN_CHECK_EN defined: misalign = (rd_en|wr_en) & !busy & (addr mod 2^size != 0 or size illegal). On a flagged store, the write is suppressed. On a flagged load, rdata = 0.
- Undefined: misalign tied to 0. Low log2(2^size) address bits are forced to 0, so the access is aligned down. Illegal size is clamped to full word.

## Structure
- Package dm_pkg holds:
  - size encodings: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2, SIZE_DWORD=3;
  - state enum: IDLE, CLEAR.
- Sub-module dm_lane_align is combinational. It does lane extraction plus sign/zero extension for loads, and byte-enable plus shifted write-data generation for stores. The top module holds the array, the FSM and the clear counter.

## Test plan
- Reset for 1 cycle, WORDS=16 -> busy=1 for exactly 16 cycles. A store issued during busy is dropped. After clear, every word reads 0.
- Store word 0x8899AABB at addr 0x8, then lb addr 0x8 signed -> 0xFFFFFFBB. lbu addr 0xB -> 0x00000088. lh addr 0xA signed -> 0xFFFF8899.
- sb 0x5A at addr 0x9 over word 0x8899AABB -> word reads 0x88995ABB. sh 0x1234 at addr 0xA -> 0x12345ABB.
- Same cycle: rd_en and wr_en of 0xCAFEF00D at addr 0x10, old value 0 -> rdata=0 that cycle, 0xCAFEF00D next cycle.
- With DM_ALIGN_CHECK_EN: sw at addr 0x6 -> misalign=1, memory unchanged. Without the macro: sw at 0x6 writes word at 0x4. Address 0x1000 with WORDS=1024 aliases 0x0.
- Reset asserted mid-clear (cycle 5 of 16) -> index restarts at 0. busy lasts 16 cycles from the final reset deassert.
